// File: rtl/uart_rx_arbiter_if.sv
// Merged character stream from the UART arbiter to the terminal writer.
// The master drives data/src/valid; the slave returns ready.
interface uart_rx_arbiter_if;
  logic [7:0] data;
  logic       src;
  logic       valid;
  logic       ready;

  modport master (output data, output src, output valid, input ready);
  modport slave  (input data, input src, input valid, output ready);
endinterface

// File: rtl/uart_rx_arbiter.sv
// Two-source UART byte merger: per-source FIFOs, round-robin output, shared baud divider.
// Optional line lock (no interleaving within a line) enabled by UART_RX_ARB_LINE_LOCK_EN.
module uart_rx_arbiter #(
  parameter int          FIFO_AW         = 4,
  parameter logic [31:0] DIVIDER_DEFAULT = 32'd217
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [7:0]          i_rx0_data,
  input  logic                i_rx0_valid,
  input  logic [7:0]          i_rx1_data,
  input  logic                i_rx1_valid,
  input  logic                i_cfg_wr,
  input  logic [31:0]         i_cfg_wdata,
  output logic [31:0]         o_cfg_divider,
  uart_rx_arbiter_if.master   out_if,
  output logic [1:0]          o_ovf,
  input  logic                i_ovf_clr
);

  localparam int               DEPTH   = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] PTR_ONE = 1;

  logic [7:0]       r_mem  [2][DEPTH];
  logic [FIFO_AW:0] r_wptr [2];
  logic [FIFO_AW:0] r_rptr [2];
  logic [7:0]       r_out_data;
  logic             r_out_src;
  logic             r_out_valid;
  logic [1:0]       r_ovf;
  logic [31:0]      r_divider;
  logic             r_rr_pri;  // source that wins the next tie

  logic [7:0] w_rx_data [2];
  logic [1:0] w_push_req, w_push, w_pop, w_empty, w_full, w_elig, w_ovf_set;
  logic       w_load, w_grant, w_sel;
  logic [7:0] w_head;

  assign w_rx_data[0] = i_rx0_data;
  assign w_rx_data[1] = i_rx1_data;
  assign w_push_req   = {i_rx1_valid, i_rx0_valid};
  assign w_load       = !r_out_valid || out_if.ready;

  always_comb begin
    w_empty = 2'b00;
    w_full  = 2'b00;
    for (int i = 0; i < 2; i++) begin
      w_empty[i] = (r_wptr[i] == r_rptr[i]);
      w_full[i]  = (r_wptr[i][FIFO_AW] != r_rptr[i][FIFO_AW]) &&
                   (r_wptr[i][FIFO_AW-1:0] == r_rptr[i][FIFO_AW-1:0]);
    end
  end

`ifdef UART_RX_ARB_LINE_LOCK_EN
  // state | meaning
  // FREE  | no line in progress, plain round-robin
  // LOCK0 | line from source 0 in progress, only source 0 loaded
  // LOCK1 | line from source 1 in progress, only source 1 loaded
  typedef enum logic [1:0] {FREE, LOCK0, LOCK1} lock_state_t;
  lock_state_t r_lock, w_lock_nxt;
  logic        w_escape;
`endif

  always_comb begin
    w_elig = ~w_empty;
`ifdef UART_RX_ARB_LINE_LOCK_EN
    w_escape = 1'b0;
    case (r_lock)
      LOCK0: begin
        if (!w_empty[0])    w_elig = 2'b01;
        else if (w_full[1]) begin w_elig = 2'b10; w_escape = 1'b1; end
        else                w_elig = 2'b00;
      end
      LOCK1: begin
        if (!w_empty[1])    w_elig = 2'b10;
        else if (w_full[0]) begin w_elig = 2'b01; w_escape = 1'b1; end
        else                w_elig = 2'b00;
      end
      default: ;
    endcase
`endif
    if (i_cfg_wr) w_elig = 2'b00;
    w_sel   = (w_elig == 2'b11) ? r_rr_pri : w_elig[1];
    w_grant = w_load && (w_elig != 2'b00);
    w_pop   = 2'b00;
    if (w_grant) w_pop[w_sel] = 1'b1;
    w_head  = r_mem[w_sel][r_rptr[w_sel][FIFO_AW-1:0]];
  end

  // A full FIFO still accepts a byte when it is popped in the same cycle.
  always_comb begin
    w_push    = 2'b00;
    w_ovf_set = 2'b00;
    for (int i = 0; i < 2; i++) begin
      w_push[i]    = w_push_req[i] && !i_cfg_wr && (!w_full[i] || w_pop[i]);
      w_ovf_set[i] = w_push_req[i] && !i_cfg_wr && !w_push[i];
    end
  end

`ifdef UART_RX_ARB_LINE_LOCK_EN
  always_comb begin
    w_lock_nxt = r_lock;
    if (i_cfg_wr)
      w_lock_nxt = FREE;
    else if (w_grant) begin
      if (w_escape || w_head == 8'h0A) w_lock_nxt = FREE;
      else                             w_lock_nxt = w_sel ? LOCK1 : LOCK0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) r_lock <= FREE;
    else         r_lock <= w_lock_nxt;
  end
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < 2; i++) begin
        r_wptr[i] <= '0;
        r_rptr[i] <= '0;
      end
      r_out_data  <= 8'h00;
      r_out_src   <= 1'b0;
      r_out_valid <= 1'b0;
      r_ovf       <= 2'b00;
      r_divider   <= DIVIDER_DEFAULT;
      r_rr_pri    <= 1'b0;
    end else begin
      if (i_cfg_wr) begin
        r_divider <= i_cfg_wdata;
        for (int i = 0; i < 2; i++) begin
          r_wptr[i] <= '0;
          r_rptr[i] <= '0;
        end
      end else begin
        for (int i = 0; i < 2; i++) begin
          if (w_push[i]) begin
            r_mem[i][r_wptr[i][FIFO_AW-1:0]] <= w_rx_data[i];
            r_wptr[i] <= r_wptr[i] + PTR_ONE;
          end
          if (w_pop[i]) r_rptr[i] <= r_rptr[i] + PTR_ONE;
        end
      end
      if (w_load) begin
        r_out_valid <= w_grant;
        if (w_grant) begin
          r_out_data <= w_head;
          r_out_src  <= w_sel;
          r_rr_pri   <= ~w_sel;
        end
      end
      r_ovf <= (r_ovf & ~{2{i_ovf_clr}}) | w_ovf_set;
    end
  end

  assign out_if.data   = r_out_data;
  assign out_if.src    = r_out_src;
  assign out_if.valid  = r_out_valid;
  assign o_ovf         = r_ovf;
  assign o_cfg_divider = r_divider;

endmodule
